rf_scoreboard: RTL

Write-side and hazard controller for the 8-entry register file (R0 hard-wired zero). It tracks in-flight destination registers issued by decode, captures results from execute and memory into a writeback register that drives the register file's dstE/dstM/valE/valM/we_ ports, and resolves decode operands by forwarding or stalling. It sits between decode, execute/memory and the register file.

---
 rtl/rf_scoreboard_pkg.sv | 17 +
 rtl/rf_scoreboard_counter.sv | 41 ++++
 rtl/rf_scoreboard.sv | 116 +++++++++++
 3 files changed

// File: rtl/rf_scoreboard_pkg.sv
// Shared types and constants for the register-file scoreboard.
// Data width, register count and write-enable polarity live here.
package rf_scoreboard_pkg;
   localparam int DATA_W = 16;
   localparam int NREG = 8;
   localparam int REG_W = 3;
   localparam logic ENABLE_ = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [REG_W-1:0] reg_t;

   typedef struct packed {
      logic stall;
      data_t val;
   } opnd_t;
endpackage

// File: rtl/rf_scoreboard_counter.sv
// sb_counter: one saturating up/down pending counter.
// Never underflows below zero and never wraps past full.
module sb_counter #(
   parameter int CNT_W = 2
) (
   input logic clk,
   input logic rst_,
   input logic inc,
   input logic dec,
   input logic dec2,
   output logic zero,
   output logic one,
   output logic full
);
   localparam logic [CNT_W-1:0] MAX = '1;

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] nxt;
   logic [CNT_W:0] up;
   logic [CNT_W:0] dn;

   always_comb begin
      up = {1'b0, cnt} + {{CNT_W{1'b0}}, inc};
      dn = '0;
      if (dec2) dn = (CNT_W+1)'(2);
      else if (dec) dn = (CNT_W+1)'(1);
      nxt = cnt;
      if (up <= dn) nxt = '0;
      else if ((up - dn) > {1'b0, MAX}) nxt = MAX;
      else nxt = CNT_W'(up - dn);
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) cnt <= '0;
      else cnt <= nxt;
   end

   assign zero = (cnt == '0);
   assign one = (cnt == CNT_W'(1));
   assign full = (cnt == MAX);
endmodule

// File: rtl/rf_scoreboard.sv
// Register-file write-side and hazard controller: pending tracking,
// writeback register, operand forwarding and decode stall.
module rf_scoreboard
   import rf_scoreboard_pkg::*;
#(
   parameter int CNT_W = 2
) (
   input logic clk,
   input logic rst_,
   input logic issue_valid,
   input logic [REG_W-1:0] issue_dst,
   input logic [REG_W-1:0] srcA,
   input logic [REG_W-1:0] srcB,
   input logic [DATA_W-1:0] rf_valA,
   input logic [DATA_W-1:0] rf_valB,
   output logic [DATA_W-1:0] opA,
   output logic [DATA_W-1:0] opB,
   output logic stall,
   input logic ex_valid,
   input logic [REG_W-1:0] ex_dst,
   input logic [DATA_W-1:0] ex_val,
   input logic mem_valid,
   input logic [REG_W-1:0] mem_dst,
   input logic [DATA_W-1:0] mem_val,
   output logic [REG_W-1:0] wb_dstE,
   output logic [REG_W-1:0] wb_dstM,
   output logic [DATA_W-1:0] wb_valE,
   output logic [DATA_W-1:0] wb_valM,
   output logic wb_we_
);
   logic [NREG-1:0] zero;
   logic [NREG-1:0] one;
   logic [NREG-1:0] full;
   logic take;
   reg_t src [2];
   data_t rfv [2];
   opnd_t res [2];

   // R0 is never tracked; clear flags keep the decoder one-hot
   assign zero[0] = 1'b0;
   assign one[0] = 1'b0;
   assign full[0] = 1'b0;

   assign take = issue_valid && !stall;

   for (genvar r = 1; r < NREG; r++) begin : g_cnt
      logic ex_hit;
      logic mem_hit;
      assign ex_hit = ex_valid && (ex_dst == REG_W'(r));
      assign mem_hit = mem_valid && (mem_dst == REG_W'(r));
      sb_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk(clk),
         .rst_(rst_),
         .inc(take && (issue_dst == REG_W'(r))),
         .dec(ex_hit ^ mem_hit),
         .dec2(ex_hit & mem_hit),
         .zero(zero[r]),
         .one(one[r]),
         .full(full[r])
      );
   end

   assign src[0] = srcA;
   assign src[1] = srcB;
   assign rfv[0] = rf_valA;
   assign rfv[1] = rf_valB;

   always_comb begin
      reg_t s;
      for (int i = 0; i < 2; i++) begin
         res[i] = '0;
         s = src[i];
         unique case (1'b1)
            (s == '0): res[i].val = '0;
            zero[s]: begin
               if (wb_we_ == ENABLE_ && wb_dstM == s)
                  res[i].val = wb_valM;
               else if (wb_we_ == ENABLE_ && wb_dstE == s)
                  res[i].val = wb_valE;
               else
                  res[i].val = rfv[i];
            end
            one[s]: begin
               if (mem_valid && mem_dst == s)
                  res[i].val = mem_val;
               else if (ex_valid && ex_dst == s)
                  res[i].val = ex_val;
               else
                  res[i].stall = 1'b1;
            end
            default: res[i].stall = 1'b1;
         endcase
      end
   end

   assign opA = res[0].val;
   assign opB = res[1].val;
   assign stall = res[0].stall || res[1].stall
      || (issue_valid && full[issue_dst]);

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         wb_dstE <= '0;
         wb_dstM <= '0;
         wb_valE <= '0;
         wb_valM <= '0;
         wb_we_ <= DISABLE_;
      end else begin
         wb_dstE <= ex_valid ? ex_dst : '0;
         wb_valE <= ex_val;
         wb_dstM <= mem_valid ? mem_dst : '0;
         wb_valM <= mem_val;
         wb_we_ <= (ex_valid || mem_valid) ? ENABLE_ : DISABLE_;
      end
   end
endmodule
